// File: rtl/tape_block_sequencer.sv
// ZX Spectrum ROM-format tape block sequencer: turns a byte stream into pilot,
// sync, data-bit and pause pulse-length commands for a downstream pulse engine.
module tape_block_sequencer #(
    parameter int PILOT_LEN     = 2168,
    parameter int PILOT_HDR_CNT = 8063,
    parameter int PILOT_DAT_CNT = 3223,
    parameter int SYNC1_LEN     = 667,
    parameter int SYNC2_LEN     = 735,
    parameter int BIT0_LEN      = 855,
    parameter int BIT1_LEN      = 1710,
    parameter int PAUSE_LEN     = 3500000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] blk_len,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [23:0] pulse_len,
    output logic        pulse_hold,
    output logic        pulse_valid,
    input  logic        pulse_ready,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        PILOT,
        SYNC1,
        SYNC2,
        DATA,
        PAUSE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] bytes_left_q, bytes_left_d;
    logic [12:0] pilot_cnt_q, pilot_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        half_q, half_d;
    logic        first_q, first_d;
    logic [7:0]  shift_q, shift_d;
    logic        byte_ready_q, byte_ready_d;
    logic [23:0] pulse_len_q, pulse_len_d;
    logic        pulse_hold_q, pulse_hold_d;
    logic        pulse_valid_q, pulse_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        pulse_xfer;
    logic        byte_xfer;
    logic [2:0]  next_idx;

    function automatic logic [23:0] bit_len(input logic b);
        return b ? 24'(BIT1_LEN) : 24'(BIT0_LEN);
    endfunction

    assign pulse_xfer = pulse_valid_q & pulse_ready;
    assign byte_xfer  = byte_ready_q & byte_valid;
    assign next_idx   = bit_idx_q - 3'd1;

    always_comb begin
        state_d       = state_q;
        bytes_left_d  = bytes_left_q;
        pilot_cnt_d   = pilot_cnt_q;
        bit_idx_d     = bit_idx_q;
        half_d        = half_q;
        first_d       = first_q;
        shift_d       = shift_q;
        byte_ready_d  = byte_ready_q;
        pulse_len_d   = pulse_len_q;
        pulse_hold_d  = pulse_hold_q;
        pulse_valid_d = pulse_valid_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        err_d         = 1'b0;

        // Abort overrides everything, including a start in the same cycle.
        if (abort) begin
            state_d       = IDLE;
            byte_ready_d  = 1'b0;
            pulse_valid_d = 1'b0;
            pulse_hold_d  = 1'b0;
            pulse_len_d   = 24'd0;
            busy_d        = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (blk_len != 16'd0) begin
                            bytes_left_d = blk_len;
                            first_d      = 1'b1;
                            busy_d       = 1'b1;
                            byte_ready_d = 1'b1;
                            state_d      = FETCH;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (byte_xfer) begin
                        byte_ready_d  = 1'b0;
                        shift_d       = byte_data;
                        bytes_left_d  = bytes_left_q - 16'd1;
                        pulse_valid_d = 1'b1;
                        pulse_hold_d  = 1'b0;
                        if (first_q) begin
                            // The flag byte picks header or data pilot length.
                            first_d     = 1'b0;
                            pilot_cnt_d = byte_data[7] ? 13'(PILOT_DAT_CNT) : 13'(PILOT_HDR_CNT);
                            pulse_len_d = 24'(PILOT_LEN);
                            state_d     = PILOT;
                        end else begin
                            bit_idx_d   = 3'd7;
                            half_d      = 1'b0;
                            pulse_len_d = bit_len(byte_data[7]);
                            state_d     = DATA;
                        end
                    end
                end
                PILOT: begin
                    if (pulse_xfer) begin
                        pilot_cnt_d = (pilot_cnt_q != 13'd0) ? pilot_cnt_q - 13'd1 : 13'd0;
                        if (pilot_cnt_q <= 13'd1) begin
                            pulse_len_d = 24'(SYNC1_LEN);
                            state_d     = SYNC1;
                        end
                    end
                end
                SYNC1: begin
                    if (pulse_xfer) begin
                        pulse_len_d = 24'(SYNC2_LEN);
                        state_d     = SYNC2;
                    end
                end
                SYNC2: begin
                    if (pulse_xfer) begin
                        bit_idx_d   = 3'd7;
                        half_d      = 1'b0;
                        pulse_len_d = bit_len(shift_q[7]);
                        state_d     = DATA;
                    end
                end
                DATA: begin
                    if (pulse_xfer) begin
                        if (!half_q) begin
                            half_d = 1'b1;
                        end else begin
                            half_d = 1'b0;
                            if (bit_idx_q != 3'd0) begin
                                bit_idx_d   = next_idx;
                                pulse_len_d = bit_len(shift_q[next_idx]);
                            end else if (bytes_left_q != 16'd0) begin
                                pulse_valid_d = 1'b0;
                                byte_ready_d  = 1'b1;
                                state_d       = FETCH;
                            end else begin
                                pulse_len_d  = 24'(PAUSE_LEN);
                                pulse_hold_d = 1'b1;
                                state_d      = PAUSE;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (pulse_xfer) begin
                        pulse_valid_d = 1'b0;
                        pulse_hold_d  = 1'b0;
                        busy_d        = 1'b0;
                        done_d        = 1'b1;
                        state_d       = IDLE;
                    end
                end
                default: begin
                    state_d       = IDLE;
                    byte_ready_d  = 1'b0;
                    pulse_valid_d = 1'b0;
                    busy_d        = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            bytes_left_q  <= 16'd0;
            pilot_cnt_q   <= 13'd0;
            bit_idx_q     <= 3'd0;
            half_q        <= 1'b0;
            first_q       <= 1'b0;
            shift_q       <= 8'd0;
            byte_ready_q  <= 1'b0;
            pulse_len_q   <= 24'd0;
            pulse_hold_q  <= 1'b0;
            pulse_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            bytes_left_q  <= bytes_left_d;
            pilot_cnt_q   <= pilot_cnt_d;
            bit_idx_q     <= bit_idx_d;
            half_q        <= half_d;
            first_q       <= first_d;
            shift_q       <= shift_d;
            byte_ready_q  <= byte_ready_d;
            pulse_len_q   <= pulse_len_d;
            pulse_hold_q  <= pulse_hold_d;
            pulse_valid_q <= pulse_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign byte_ready  = byte_ready_q;
    assign pulse_len   = pulse_len_q;
    assign pulse_hold  = pulse_hold_q;
    assign pulse_valid = pulse_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_tape_block_sequencer.sv
// Scoreboard bench for tape_block_sequencer: expected pulse commands are queued
// when a block is started and compared as the pulse engine accepts them.
module tb_tape_block_sequencer;

    localparam int PILOT_LEN     = 2168;
    localparam int PILOT_HDR_CNT = 8063;
    localparam int PILOT_DAT_CNT = 3223;
    localparam int SYNC1_LEN     = 667;
    localparam int SYNC2_LEN     = 735;
    localparam int BIT0_LEN      = 855;
    localparam int BIT1_LEN      = 1710;
    localparam int PAUSE_LEN     = 3500000;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [15:0] blk_len;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic [23:0] pulse_len;
    logic        pulse_hold;
    logic        pulse_valid;
    logic        pulse_ready;
    logic        busy;
    logic        done;
    logic        err;

    tape_block_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .blk_len    (blk_len),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .pulse_len  (pulse_len),
        .pulse_hold (pulse_hold),
        .pulse_valid(pulse_valid),
        .pulse_ready(pulse_ready),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    logic [24:0] exp_q[$];
    logic [7:0]  byte_q[$];
    logic [7:0]  blk[$];

    int   extra       = 0;
    int   stab_viol   = 0;
    int   done_cnt    = 0;
    int   pulses_seen = 0;
    int   bytes_sent  = 0;
    int   stv_idx     = -1;
    int   stv_cnt     = 0;
    int   stv_viol    = 0;
    bit   bp          = 1'b0;
    bit   withhold    = 1'b0;
    bit   bxfer       = 1'b0;
    bit   prev_pend   = 1'b0;
    bit   prev_abort  = 1'b0;
    logic [24:0] prev_cmd = '0;
    logic [24:0] mon_e;

    // Pulse-side monitor: scoreboard pop, stability under backpressure, done.
    always @(negedge clk) begin
        if (reset_n) begin
            if (pulse_valid && pulse_ready) begin
                pulses_seen++;
                if (exp_q.size() == 0) begin
                    extra++;
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pulse_cmd", {7'd0, pulse_hold, pulse_len}, {7'd0, mon_e});
                end
            end
            if (prev_pend && !prev_abort && (!pulse_valid || ({pulse_hold, pulse_len} != prev_cmd)))
                stab_viol++;
            prev_pend  = pulse_valid && !pulse_ready;
            prev_cmd   = {pulse_hold, pulse_len};
            prev_abort = abort;
            if (done) begin
                done_cnt++;
                check("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    // Byte source, with optional starvation before byte number stv_idx.
    initial begin
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        forever begin
            @(negedge clk);
            bxfer = byte_valid && byte_ready;
            if (withhold && byte_ready && pulse_valid) stv_viol++;
            @(posedge clk);
            #1;
            if (bxfer && byte_q.size() > 0) begin
                void'(byte_q.pop_front());
                bytes_sent++;
            end
            withhold = (bytes_sent == stv_idx) && (stv_cnt > 0);
            if (withhold && byte_ready) stv_cnt--;
            byte_valid = (byte_q.size() > 0) && !withhold;
            byte_data  = (byte_q.size() > 0) ? byte_q[0] : 8'd0;
        end
    end

    initial begin
        pulse_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pulse_ready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    task automatic build_exp(output int total);
        int pc;
        logic [23:0] l;
        pc = blk[0][7] ? PILOT_DAT_CNT : PILOT_HDR_CNT;
        for (int i = 0; i < pc; i++) exp_q.push_back({1'b0, 24'(PILOT_LEN)});
        exp_q.push_back({1'b0, 24'(SYNC1_LEN)});
        exp_q.push_back({1'b0, 24'(SYNC2_LEN)});
        foreach (blk[k]) begin
            for (int b = 7; b >= 0; b--) begin
                l = blk[k][b] ? 24'(BIT1_LEN) : 24'(BIT0_LEN);
                exp_q.push_back({1'b0, l});
                exp_q.push_back({1'b0, l});
            end
        end
        exp_q.push_back({1'b1, 24'(PAUSE_LEN)});
        total = pc + 2 + 16 * blk.size() + 1;
    endtask

    task automatic start_block(output int total);
        byte_q     = blk;
        bytes_sent = 0;
        build_exp(total);
        @(posedge clk); #1;
        start   = 1'b1;
        blk_len = 16'(blk.size());
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input string tag, input int budget, input int total);
        int d0;
        int p0;
        int n;
        d0 = done_cnt;
        p0 = pulses_seen;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_extra"}, 32'(extra), 32'd0);
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        check({tag, "_pulse_total"}, 32'(pulses_seen - p0), 32'(total));
    endtask

    int tot;
    int p0;
    int n;
    int d0;

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        blk_len = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_pulse_valid", {31'd0, pulse_valid}, 32'd0);
        check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done_err", {30'd0, done, err}, 32'd0);
        check("rst_pulse_len", {7'd0, pulse_hold, pulse_len}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Header block, 19 bytes, engine always ready.
        blk.delete();
        blk.push_back(8'h00);
        for (int i = 0; i < 18; i++) blk.push_back(8'($urandom_range(0, 255)));
        start_block(tot);
        p0 = pulses_seen;
        wait_done("hdr", 12000, tot);

        // Data block from the test plan.
        blk.delete();
        blk.push_back(8'hFF);
        blk.push_back(8'hA5);
        start_block(tot);
        wait_done("dat", 6000, tot);

        // Random backpressure on the pulse engine.
        bp = 1'b1;
        blk.delete();
        blk.push_back(8'h80 | 8'($urandom_range(0, 127)));
        for (int i = 0; i < 3; i++) blk.push_back(8'($urandom_range(0, 255)));
        start_block(tot);
        wait_done("bp", 25000, tot);
        bp = 1'b0;
        check("bp_stable", 32'(stab_viol), 32'd0);

        // Second byte withheld for 50 FETCH cycles.
        stv_idx  = 1;
        stv_cnt  = 50;
        stv_viol = 0;
        blk.delete();
        blk.push_back(8'hFF);
        blk.push_back(8'h3C);
        blk.push_back(8'hC3);
        start_block(tot);
        wait_done("starve", 6000, tot);
        check("starve_happened", 32'(stv_cnt), 32'd0);
        check("starve_no_pulse", 32'(stv_viol), 32'd0);
        stv_idx = -1;

        // Abort in the middle of the data bits.
        blk.delete();
        blk.push_back(8'hFF);
        blk.push_back(8'h12);
        blk.push_back(8'h34);
        start_block(tot);
        p0 = pulses_seen;
        n  = 0;
        while ((pulses_seen - p0) < (PILOT_DAT_CNT + 2 + 6) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach_data", {31'd0, (pulses_seen - p0) >= (PILOT_DAT_CNT + 2 + 6)}, 32'd1);
        d0 = done_cnt;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_valid", {31'd0, pulse_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_byte_ready", {31'd0, byte_ready}, 32'd0);
        repeat (20) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_still_idle", {30'd0, busy, pulse_valid}, 32'd0);
        exp_q.delete();
        byte_q.delete();
        repeat (3) @(negedge clk);
        extra = 0;

        blk.delete();
        blk.push_back(8'h00);
        blk.push_back(8'h5A);
        start_block(tot);
        wait_done("after_abort", 12000, tot);

        // Zero-length start.
        @(posedge clk); #1;
        start   = 1'b1;
        blk_len = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("err_pulse", {31'd0, err}, 32'd1);
        check("err_busy", {31'd0, busy}, 32'd0);
        check("err_byte_ready", {31'd0, byte_ready}, 32'd0);
        @(negedge clk);
        check("err_one_cycle", {31'd0, err}, 32'd0);

        // start together with abort.
        @(posedge clk); #1;
        start   = 1'b1;
        abort   = 1'b1;
        blk_len = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("sa_busy", {31'd0, busy}, 32'd0);
        check("sa_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("sa_err", {31'd0, err}, 32'd0);
        repeat (3) @(negedge clk);
        check("sa_still_idle", {30'd0, busy, byte_ready}, 32'd0);

        check("stable_overall", 32'(stab_viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
